lcd_glyph_serializer: RTL



---
 rtl/lcd_pkg.sv | 24 ++
 rtl/glyph_shifter.sv | 72 +++++++
 rtl/lcd_glyph_serializer.sv | 96 +++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// ============================================================================
// Module   : lcd_pkg
// Brief    : Shared font geometry constants and fetch-FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

  localparam int CHAR_W     = 7;
  localparam int ROW_W      = 4;
  localparam int GLYPH_W    = 8;
  localparam int FONT_DEPTH = 2048;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_CAPT = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/glyph_shifter.sv
// ============================================================================
// Module   : glyph_shifter
// Brief    : One-byte hold buffer feeding an 8-bit pixel shift register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module glyph_shifter
  import lcd_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_hold_wr,
  input  logic [GLYPH_W-1:0] i_hold_data,
  output logic               o_hold_full,
  input  logic               i_pix_ready,
  output logic               o_pix_valid,
  output logic               o_pix,
  output logic               o_pix_last
);

  logic [GLYPH_W-1:0] r_hold;
  logic               r_hold_full;
  logic [GLYPH_W-1:0] r_sh;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_fire;
  logic               w_load;
  logic [GLYPH_W-1:0] w_sh_shifted;

  assign o_pix_valid = (r_cnt != '0);
  assign o_pix_last  = (r_cnt == CNT_W'(1));
  assign o_pix       = MSB_FIRST ? r_sh[GLYPH_W-1] : r_sh[0];
  assign o_hold_full = r_hold_full;

  assign w_fire = o_pix_valid && i_pix_ready;
  // Reload on the last pixel's handshake as well as when empty, so rows abut.
  assign w_load = r_hold_full && ((r_cnt == '0) || (o_pix_last && w_fire));

  assign w_sh_shifted = MSB_FIRST ? {r_sh[GLYPH_W-2:0], 1'b0}
                                  : {1'b0, r_sh[GLYPH_W-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (i_hold_wr) begin
      r_hold      <= i_hold_data;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_sh  <= r_hold;
      r_cnt <= CNT_W'(GLYPH_W);
    end else if (w_fire) begin
      r_sh  <= w_sh_shifted;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_glyph_serializer.sv
// ============================================================================
// Module   : lcd_glyph_serializer
// Brief    : Fetches glyph rows from the font ROM and serializes them to pixels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_glyph_serializer #(
  parameter int CHAR_W    = lcd_pkg::CHAR_W,
  parameter int ROW_W     = lcd_pkg::ROW_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CHAR_W-1:0] req_char,
  input  logic [ROW_W-1:0]  req_row,
  output logic [31:0]       rom_addr,
  input  logic [7:0]        rom_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix,
  output logic              pix_last
);

  import lcd_pkg::*;

  localparam int PAD_W = 32 - CHAR_W - ROW_W;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_rom_addr;
  logic         w_req_ready;
  logic         w_accept;
  logic         w_hold_wr;
  logic         w_hold_full;

  assign w_accept  = req_valid && w_req_ready;
  assign req_ready = w_req_ready;
  assign rom_addr  = r_rom_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= F_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      F_IDLE:  if (w_accept) w_state_nxt = F_WAIT;
      F_WAIT:  w_state_nxt = F_CAPT;
      F_CAPT:  w_state_nxt = F_IDLE;
      default: w_state_nxt = F_IDLE;
    endcase
  end

  // Only one fetch in flight, and only when the hold slot is free to receive it.
  always_comb begin
    w_req_ready = 1'b0;
    w_hold_wr   = 1'b0;
    case (r_state)
      F_IDLE:  w_req_ready = !w_hold_full;
      F_CAPT:  w_hold_wr   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_addr <= '0;
    end else if (w_accept) begin
      r_rom_addr <= {{PAD_W{1'b0}}, req_char, req_row};
    end
  end

  glyph_shifter #(
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_hold_wr   (w_hold_wr),
    .i_hold_data (rom_data),
    .o_hold_full (w_hold_full),
    .i_pix_ready (pix_ready),
    .o_pix_valid (pix_valid),
    .o_pix       (pix),
    .o_pix_last  (pix_last)
  );

endmodule

`default_nettype wire
